// File: rtl/alu_flags_wb.sv
// ALU writeback consumer: derives ZF/SF/PF, commits masked flags, evaluates
// x86 condition codes, and buffers results in a 2-entry queue toward writeback.
module alu_flags_wb #(
  parameter int W      = 32,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_result,
  input  logic              in_cf,
  input  logic              in_af,
  input  logic              in_of,
  input  logic [5:0]        in_fmask,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_we,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [W-1:0]      wb_result,
  output logic [DEST_W-1:0] wb_dest,
  output logic              wb_we,
  input  logic              flags_ld,
  input  logic [5:0]        flags_ld_val,
  output logic [5:0]        flags,
  input  logic [3:0]        cc_sel,
  output logic              cc_true
);

  localparam int F_CF = 0;
  localparam int F_PF = 1;
  localparam int F_AF = 2;
  localparam int F_ZF = 3;
  localparam int F_SF = 4;
  localparam int F_OF = 5;

  typedef struct packed {
    logic [W-1:0]      result;
    logic [DEST_W-1:0] dest;
    logic              we;
  } entry_t;

  entry_t      r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [5:0]  r_flags;

  logic        w_enq;
  logic        w_deq;
  logic [5:0]  w_new_flags;
  logic [5:0]  w_next_flags;
  logic        w_base;

  assign in_ready = (r_count != 2'd2);
  assign wb_valid = (r_count != 2'd0);
  assign w_enq    = in_valid && in_ready;
  assign w_deq    = wb_valid && wb_ready;

  assign wb_result = r_mem[r_rd_ptr].result;
  assign wb_dest   = r_mem[r_rd_ptr].dest;
  assign wb_we     = r_mem[r_rd_ptr].we;
  assign flags     = r_flags;

  // Flags are derived from the word being accepted, so they commit at enqueue time.
  always_comb begin
    w_new_flags       = '0;
    w_new_flags[F_CF] = in_cf;
    w_new_flags[F_PF] = ~^in_result[7:0];
    w_new_flags[F_AF] = in_af;
    w_new_flags[F_ZF] = (in_result == '0);
    w_new_flags[F_SF] = in_result[W-1];
    w_new_flags[F_OF] = in_of;

    w_next_flags = r_flags;
    if (flags_ld) begin
      w_next_flags = flags_ld_val;
    end else if (w_enq) begin
      w_next_flags = (r_flags & ~in_fmask) | (w_new_flags & in_fmask);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the two queue entries are reset so wb_* read as zero out of reset;
    // they are few enough that clearing them costs nothing worth avoiding.
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_flags  <= 6'h00;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= '{result: in_result, dest: in_dest, we: in_we};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) r_rd_ptr <= ~r_rd_ptr;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      r_flags <= w_next_flags;
    end
  end

  // Jcc pairs: odd codes are the negation of the preceding even code.
  always_comb begin
    w_base = 1'b0;
    case (cc_sel[3:1])
      3'd0:    w_base = r_flags[F_OF];
      3'd1:    w_base = r_flags[F_CF];
      3'd2:    w_base = r_flags[F_ZF];
      3'd3:    w_base = r_flags[F_CF] | r_flags[F_ZF];
      3'd4:    w_base = r_flags[F_SF];
      3'd5:    w_base = r_flags[F_PF];
      3'd6:    w_base = r_flags[F_SF] ^ r_flags[F_OF];
      default: w_base = r_flags[F_ZF] | (r_flags[F_SF] ^ r_flags[F_OF]);
    endcase
    cc_true = w_base ^ cc_sel[0];
  end

endmodule

// File: tb/tb_alu_flags_wb.sv
// Directed plus random bench for alu_flags_wb against a queue-based reference model.
module tb_alu_flags_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_cf, in_af, in_of;
  logic [5:0]  in_fmask;
  logic [2:0]  in_dest;
  logic        in_we;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [2:0]  wb_dest;
  logic        wb_we;
  logic        flags_ld;
  logic [5:0]  flags_ld_val;
  logic [5:0]  flags;
  logic [3:0]  cc_sel;
  logic        cc_true;

  always #5 clk = ~clk;

  alu_flags_wb #(.W(32), .DEST_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_cf(in_cf), .in_af(in_af), .in_of(in_of), .in_fmask(in_fmask),
    .in_dest(in_dest), .in_we(in_we),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_dest(wb_dest), .wb_we(wb_we),
    .flags_ld(flags_ld), .flags_ld_val(flags_ld_val), .flags(flags),
    .cc_sel(cc_sel), .cc_true(cc_true)
  );

  typedef struct {
    logic [31:0] r;
    logic [2:0]  d;
    logic        we;
  } ent_t;

  ent_t        mq[$];
  logic [5:0]  m_flags;
  logic [31:0] got[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Condition codes written out one mnemonic at a time from the flag meanings.
  function automatic logic cc_ref(input logic [3:0] s, input logic [5:0] f);
    logic o, sg, z, p, c;
    o = f[5]; sg = f[4]; z = f[3]; p = f[1]; c = f[0];
    case (s)
      4'h0: return o;                  // O
      4'h1: return !o;                 // NO
      4'h2: return c;                  // B
      4'h3: return !c;                 // AE
      4'h4: return z;                  // E
      4'h5: return !z;                 // NE
      4'h6: return c || z;             // BE
      4'h7: return !(c || z);          // A
      4'h8: return sg;                 // S
      4'h9: return !sg;                // NS
      4'hA: return p;                  // P
      4'hB: return !p;                 // NP
      4'hC: return sg != o;            // L
      4'hD: return sg == o;            // GE
      4'hE: return z || (sg != o);     // LE
      default: return !(z || (sg != o)); // G
    endcase
  endfunction

  task automatic check_state();
    check("in_ready", in_ready, mq.size() < 2);
    check("wb_valid", wb_valid, mq.size() > 0);
    check("flags", flags, m_flags);
    check("cc_true", cc_true, cc_ref(cc_sel, m_flags));
    if (mq.size() > 0) begin
      check("wb_result", wb_result, mq[0].r);
      check("wb_dest", wb_dest, mq[0].d);
      check("wb_we", wb_we, mq[0].we);
    end
  endtask

  // One clock: check settled outputs, take the edge, advance the model.
  task automatic cycle();
    bit enq, deq;
    logic [5:0] nf;
    #1;
    check_state();
    enq = in_valid && (mq.size() < 2);
    deq = wb_ready && (mq.size() > 0);
    if (deq && wb_valid) got.push_back(wb_result);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_flags = 6'h00;
    end else begin
      nf = {in_of, in_result[31], in_result == 32'd0, in_af,
            ($countones(in_result[7:0]) % 2) == 0, in_cf};
      if (flags_ld) m_flags = flags_ld_val;
      else if (enq) begin
        for (int i = 0; i < 6; i++) if (in_fmask[i]) m_flags[i] = nf[i];
      end
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back('{r: in_result, d: in_dest, we: in_we});
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_result = '0; in_cf = 0; in_af = 0; in_of = 0;
    in_fmask = 6'h3F; in_dest = 3'd1; in_we = 1'b1; wb_ready = 0;
    flags_ld = 0; flags_ld_val = '0; cc_sel = 4'h0;
    m_flags = 6'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_flags", flags, 6'h00);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_wb_dest", wb_dest, 3'd0);
    check("rst_wb_we", wb_we, 1'b0);

    // Zero result with carry
    in_valid = 1; in_result = 32'd0; in_cf = 1; in_fmask = 6'h3F;
    cycle();
    in_valid = 0;
    check("t1_flags", flags, 6'h0B);
    check("t1_wb_valid", wb_valid, 1'b1);
    check("t1_wb_result", wb_result, 32'd0);
    cc_sel = 4'h4; #1 check("t1_cc_E", cc_true, 1'b1);
    cc_sel = 4'h7; #1 check("t1_cc_A", cc_true, 1'b0);

    // Negative result with overflow, concurrent dequeue of previous entry
    wb_ready = 1; in_valid = 1; in_result = 32'h8000_0001; in_of = 1; in_cf = 0; in_dest = 3'd2;
    cycle();
    in_valid = 0;
    check("t2_flags", flags, 6'h30);
    check("t2_wb_result", wb_result, 32'h8000_0001);
    cc_sel = 4'h0; #1 check("t2_cc_O", cc_true, 1'b1);
    cc_sel = 4'hC; #1 check("t2_cc_L", cc_true, 1'b0);
    cc_sel = 4'hA; #1 check("t2_cc_P", cc_true, 1'b0);

    // CF-only mask
    in_valid = 1; in_result = 32'd0; in_fmask = 6'h01; in_cf = 1; in_of = 0;
    cycle();
    in_valid = 0;
    check("t3_flags", flags, 6'h31);

    // Back-pressure: fill, stall, drain in order
    cycle(); cycle();
    got.delete();
    wb_ready = 0; in_fmask = 6'h3F;
    in_valid = 1; in_result = 32'd1; cycle();
    in_result = 32'd2; cycle();
    in_result = 32'd3; cycle();
    check("t4_in_ready_full", in_ready, 1'b0);
    check("t4_head_held", wb_result, 32'd1);
    cycle();
    check("t4_head_stable", wb_result, 32'd1);
    wb_ready = 1;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (mq.size() == 2 || !in_ready) in_valid = in_valid;
      cycle();
      if (mq.size() > 0 && mq[$].r == 32'd3) in_valid = 0;
    end
    in_valid = 0;
    check("t4_drain_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t4_seq0", got[0], 32'd1);
      check("t4_seq1", got[1], 32'd2);
      check("t4_seq2", got[2], 32'd3);
    end

    // Direct load beats same-cycle enqueue update
    flags_ld = 1; flags_ld_val = 6'h2A; in_valid = 1; in_result = 32'd0; wb_ready = 0;
    cycle();
    flags_ld = 0; in_valid = 0;
    check("t5_flags", flags, 6'h2A);
    check("t5_enqueued", wb_valid, 1'b1);

    // Reset while full
    in_valid = 1; in_result = 32'd5; cycle();
    in_valid = 0;
    check("t6_full", in_ready, 1'b0);
    rst_n = 0; cycle(); rst_n = 1;
    check("t6_wb_valid", wb_valid, 1'b0);
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_flags", flags, 6'h00);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst_n        = ($urandom_range(0, 63) != 0);
      in_valid     = $urandom_range(0, 2) != 0;
      in_result    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      in_cf        = 1'($urandom); in_af = 1'($urandom); in_of = 1'($urandom);
      in_fmask     = 6'($urandom);
      in_dest      = 3'($urandom);
      in_we        = 1'($urandom);
      wb_ready     = $urandom_range(0, 2) != 0;
      flags_ld     = ($urandom_range(0, 9) == 0);
      flags_ld_val = 6'($urandom);
      cc_sel       = 4'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
